// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the banked instruction memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  localparam int unsigned NOP_MAX_W = 64;
  localparam logic [NOP_MAX_W-1:0] NOP_INSTR_DEFAULT = '0;

endpackage

// File: rtl/instr_bank_ram.sv
// Single-port word array holding all program banks; synchronous write, registered read.
module instr_bank_ram #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned WORDS = 256,
  localparam int unsigned AW = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [WORDS];
  logic [WIDTH-1:0] rdata_q;

  // Read register only advances on a real fetch so a stall keeps the last word.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem.sv
// Banked instruction fetch memory with stall/flush control, bank switching and a
// loader port that is only open while the fetch engine is idle.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned BANKS   = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [BANK_W-1:0]  bank_sel,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [BANK_W-1:0]  load_bank,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               pc_fault
);

  localparam int unsigned DAW    = $clog2(DEPTH);
  localparam int unsigned RAM_AW = $clog2(BANKS * DEPTH);

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                sel_q, sel_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic                load_ready_q, load_ready_d;

  logic                pc_oob_c, load_oob_c;
  logic                ram_we_c, ram_re_c;
  logic [RAM_AW-1:0]   ram_addr_c;
  logic [INSTR_W-1:0]  ram_rdata;

  assign pc_oob_c   = pc_in >= ADDR_W'(DEPTH);
  assign load_oob_c = load_addr >= ADDR_W'(DEPTH);
  assign ram_we_c   = load_valid && load_ready_q && !load_oob_c;

  // The single RAM port belongs to the loader in IDLE and to fetch otherwise.
  assign ram_addr_c = (state_q == ST_IDLE)
                    ? RAM_AW'({load_bank, load_addr[DAW-1:0]})
                    : RAM_AW'({bank_q, pc_in[DAW-1:0]});

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    ram_re_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sel_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b0;
        if (fetch_en) state_d = ST_RUN;
      end
      default: begin
        if (!fetch_en) begin
          state_d = ST_IDLE;
          sel_d   = 1'b0;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else if (state_q == ST_RUN && bank_sel != bank_q) begin
          state_d = ST_SWITCH;
          bank_d  = bank_sel;
          sel_d   = 1'b0;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else begin
          // SWITCH spends its cycle as the bubble and fetches from the new bank on exit.
          state_d = ST_RUN;
          if (flush) begin
            sel_d   = 1'b0;
            valid_d = 1'b0;
            fault_d = 1'b0;
          end else if (!stall) begin
            valid_d = 1'b1;
            if (pc_oob_c) begin
              sel_d   = 1'b0;
              fault_d = 1'b1;
            end else begin
              sel_d    = 1'b1;
              fault_d  = 1'b0;
              ram_re_c = 1'b1;
            end
          end
        end
      end
    endcase
    load_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bank_q       <= '0;
      sel_q        <= 1'b0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      sel_q        <= sel_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      load_ready_q <= load_ready_d;
    end
  end

  instr_bank_ram #(
    .WIDTH (INSTR_W),
    .WORDS (BANKS * DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .addr  (ram_addr_c),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  assign instr_out   = sel_q ? ram_rdata : NOP_INSTR;
  assign instr_valid = valid_q;
  assign pc_fault    = fault_q;
  assign load_ready  = load_ready_q;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: vector table plus hand-written corner sequences.
module tb_instr_mem;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned BANKS   = 4;
  localparam logic [8:0]  NOP     = 9'h000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en, stall, flush;
  logic [15:0] pc_in;
  logic [1:0]  bank_sel;
  logic        load_valid;
  logic        load_ready;
  logic [1:0]  load_bank;
  logic [15:0] load_addr;
  logic [8:0]  load_data;
  logic [8:0]  instr_out;
  logic        instr_valid;
  logic        pc_fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0] instr;
    logic       valid;
    logic       fault;
    logic       ready;
  } exp_t;

  typedef struct {
    string       name;
    logic        fen, stl, fls;
    logic [1:0]  bank;
    logic [15:0] pc;
    logic [8:0]  e_instr;
    logic        e_valid, e_fault, e_ready;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  instr_mem #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .BANKS   (BANKS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .flush       (flush),
    .pc_in       (pc_in),
    .bank_sel    (bank_sel),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_bank   (load_bank),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_fault    (pc_fault)
  );

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (instr_out !== e.instr || instr_valid !== e.valid ||
        pc_fault !== e.fault || load_ready !== e.ready) begin
      errors++;
      $display("FAIL %s: got instr=%h valid=%b fault=%b ready=%b, want instr=%h valid=%b fault=%b ready=%b",
               name, instr_out, instr_valid, pc_fault, load_ready,
               e.instr, e.valid, e.fault, e.ready);
    end
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    compare(name, e);
  endtask

  task automatic step(input string name, input logic fen, input logic stl, input logic fls,
                      input logic [1:0] bank, input logic [15:0] pc,
                      input logic [8:0] e_instr, input logic e_valid,
                      input logic e_fault, input logic e_ready);
    fetch_en = fen;
    stall    = stl;
    flush    = fls;
    bank_sel = bank;
    pc_in    = pc;
    sb_q.push_back('{instr: e_instr, valid: e_valid, fault: e_fault, ready: e_ready});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic load_word(input logic [1:0] bank, input logic [15:0] addr, input logic [8:0] data);
    load_valid = 1'b1;
    load_bank  = bank;
    load_addr  = addr;
    load_data  = data;
    step("idle_load", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, NOP, 1'b0, 1'b0, 1'b1);
    load_valid = 1'b0;
  endtask

  function automatic void add(input string n, input logic fen, input logic stl, input logic fls,
                              input logic [1:0] bank, input logic [15:0] pc,
                              input logic [8:0] ei, input logic ev, input logic ef, input logic er);
    vecs.push_back('{name: n, fen: fen, stl: stl, fls: fls, bank: bank, pc: pc,
                     e_instr: ei, e_valid: ev, e_fault: ef, e_ready: er});
  endfunction

  initial begin
    reset = 1'b1; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
    pc_in = '0; bank_sel = '0; load_valid = 1'b0; load_bank = '0;
    load_addr = '0; load_data = '0;

    //        name              fen stl fls bank pc     instr   v     f     rdy
    add("f7",             1'b1, 1'b0, 1'b0, 2'd0, 16'd7,  9'h077, 1'b1, 1'b0, 1'b0);
    add("f0",             1'b1, 1'b0, 1'b0, 2'd0, 16'd0,  9'h001, 1'b1, 1'b0, 1'b0);
    add("f1",             1'b1, 1'b0, 1'b0, 2'd0, 16'd1,  9'h110, 1'b1, 1'b0, 1'b0);
    add("f2",             1'b1, 1'b0, 1'b0, 2'd0, 16'd2,  9'h010, 1'b1, 1'b0, 1'b0);
    add("f3",             1'b1, 1'b0, 1'b0, 2'd0, 16'd3,  9'h171, 1'b1, 1'b0, 1'b0);
    add("oob_wr_discard", 1'b1, 1'b0, 1'b0, 2'd0, 16'd6,  9'h066, 1'b1, 1'b0, 1'b0);
    add("f63_top_word",   1'b1, 1'b0, 1'b0, 2'd0, 16'd63, 9'h13F, 1'b1, 1'b0, 1'b0);
    add("pc70_fault",     1'b1, 1'b0, 1'b0, 2'd0, 16'd70, NOP,    1'b1, 1'b1, 1'b0);
    add("f5",             1'b1, 1'b0, 1'b0, 2'd0, 16'd5,  9'h0C3, 1'b1, 1'b0, 1'b0);
    add("stall_a",        1'b1, 1'b1, 1'b0, 2'd0, 16'd6,  9'h0C3, 1'b1, 1'b0, 1'b0);
    add("stall_b",        1'b1, 1'b1, 1'b0, 2'd0, 16'd7,  9'h0C3, 1'b1, 1'b0, 1'b0);
    add("stall_c",        1'b1, 1'b1, 1'b0, 2'd0, 16'd8,  9'h0C3, 1'b1, 1'b0, 1'b0);
    add("pc64_fault",     1'b1, 1'b0, 1'b0, 2'd0, 16'd64, NOP,    1'b1, 1'b1, 1'b0);
    add("stall_fault",    1'b1, 1'b1, 1'b0, 2'd0, 16'd0,  NOP,    1'b1, 1'b1, 1'b0);
    add("f1_again",       1'b1, 1'b0, 1'b0, 2'd0, 16'd1,  9'h110, 1'b1, 1'b0, 1'b0);
    add("stall_flush",    1'b1, 1'b1, 1'b1, 2'd0, 16'd2,  NOP,    1'b0, 1'b0, 1'b0);
    add("flush_only",     1'b1, 1'b0, 1'b1, 2'd0, 16'd3,  NOP,    1'b0, 1'b0, 1'b0);
    add("f3_after_flush", 1'b1, 1'b0, 1'b0, 2'd0, 16'd3,  9'h171, 1'b1, 1'b0, 1'b0);
    add("switch_bubble",  1'b1, 1'b0, 1'b0, 2'd2, 16'd0,  NOP,    1'b0, 1'b0, 1'b0);
    add("b2_w0",          1'b1, 1'b0, 1'b0, 2'd2, 16'd0,  9'h1AA, 1'b1, 1'b0, 1'b0);
    add("b2_w1",          1'b1, 1'b0, 1'b0, 2'd2, 16'd1,  9'h055, 1'b1, 1'b0, 1'b0);
    add("switch_back",    1'b1, 1'b0, 1'b0, 2'd0, 16'd2,  NOP,    1'b0, 1'b0, 1'b0);
    add("b0_w2",          1'b1, 1'b0, 1'b0, 2'd0, 16'd2,  9'h010, 1'b1, 1'b0, 1'b0);

    #12;
    compare("reset_state", '{instr: NOP, valid: 1'b0, fault: 1'b0, ready: 1'b1});
    reset = 1'b0;

    load_word(2'd0, 16'd0,  9'h001);
    load_word(2'd0, 16'd1,  9'h110);
    load_word(2'd0, 16'd2,  9'h010);
    load_word(2'd0, 16'd3,  9'h171);
    load_word(2'd0, 16'd5,  9'h0C3);
    load_word(2'd0, 16'd6,  9'h066);
    load_word(2'd0, 16'd63, 9'h13F);
    load_word(2'd2, 16'd0,  9'h1AA);
    load_word(2'd2, 16'd1,  9'h055);
    load_word(2'd2, 16'd2,  9'h0F0);
    load_word(2'd0, 16'd70, 9'h1FF);

    // Write lands on the same edge that moves IDLE to RUN.
    load_valid = 1'b1; load_bank = 2'd0; load_addr = 16'd7; load_data = 9'h077;
    step("idle_to_run_wr", 1'b1, 1'b0, 1'b0, 2'd0, 16'd7, NOP, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b0;

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].fen, vecs[i].stl, vecs[i].fls, vecs[i].bank, vecs[i].pc,
           vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_fault, vecs[i].e_ready);

    // Loader held off during RUN, then accepted once back in IDLE.
    load_valid = 1'b1; load_bank = 2'd0; load_addr = 16'd0; load_data = 9'h1FF;
    step("ld_in_run_a", 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 9'h001, 1'b1, 1'b0, 1'b0);
    step("ld_in_run_b", 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 9'h001, 1'b1, 1'b0, 1'b0);
    step("ld_in_run_c", 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 9'h001, 1'b1, 1'b0, 1'b0);
    step("run_to_idle", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, NOP,    1'b0, 1'b0, 1'b1);
    step("idle_write",  1'b0, 1'b0, 1'b0, 2'd0, 16'd0, NOP,    1'b0, 1'b0, 1'b1);
    load_valid = 1'b0;
    step("rerun",       1'b1, 1'b0, 1'b0, 2'd0, 16'd0, NOP,    1'b0, 1'b0, 1'b0);
    step("fetch_new",   1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 9'h1FF, 1'b1, 1'b0, 1'b0);
    step("pre_reset",   1'b1, 1'b0, 1'b0, 2'd0, 16'd3, 9'h171, 1'b1, 1'b0, 1'b0);

    // Reset between edges must clear outputs without a clock.
    #3;
    reset = 1'b1;
    #1;
    compare("async_reset", '{instr: NOP, valid: 1'b0, fault: 1'b0, ready: 1'b1});
    #2;
    reset = 1'b0;
    step("post_rst_idle",  1'b1, 1'b0, 1'b0, 2'd0, 16'd1, NOP,    1'b0, 1'b0, 1'b0);
    step("post_rst_fetch", 1'b1, 1'b0, 1'b0, 2'd0, 16'd1, 9'h110, 1'b1, 1'b0, 1'b0);
    step("post_rst_sw",    1'b1, 1'b0, 1'b0, 2'd2, 16'd2, NOP,    1'b0, 1'b0, 1'b0);
    step("post_rst_b2",    1'b1, 1'b0, 1'b0, 2'd2, 16'd2, 9'h0F0, 1'b1, 1'b0, 1'b0);
    step("final_idle",     1'b0, 1'b0, 1'b0, 2'd2, 16'd0, NOP,    1'b0, 1'b0, 1'b1);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
